// File: rtl/sync_fifo_lvl_if.sv
// Producer/consumer bundle for sync_fifo_lvl: write/read requests, flush,
// programmable level thresholds, read data and the occupancy/error flags.
interface sync_fifo_lvl_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    // winc/rinc are requests, not handshakes: a request is accepted on a rising
    // edge only if the FIFO is not full/empty and flush is low. A refused
    // request sets the matching sticky error flag and is not retried.
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic             flush;
    logic [ASIZE:0]   af_level;
    logic [ASIZE:0]   ae_level;
    logic [DSIZE-1:0] rdata;
    logic [ASIZE:0]   count;
    logic             wfull;
    logic             tfull;
    logic             hfull;
    logic             qfull;
    logic             rempty;
    logic             afull;
    logic             aempty;
    logic             wovf;
    logic             rudf;

    modport master (
        output wdata, winc, rinc, flush, af_level, ae_level,
        input  rdata, count, wfull, tfull, hfull, qfull, rempty,
               afull, aempty, wovf, rudf
    );

    modport slave (
        input  wdata, winc, rinc, flush, af_level, ae_level,
        output rdata, count, wfull, tfull, hfull, qfull, rempty,
               afull, aempty, wovf, rudf
    );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with word count, fixed quarter-level flags, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky errors.
module sync_fifo_lvl #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic clk,
    input  logic rst_n,
    sync_fifo_lvl_if.slave bus
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] LVL_FULL = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] LVL_TQ   = (ASIZE+1)'((3 * DEPTH) / 4);
    localparam logic [ASIZE:0] LVL_HALF = (ASIZE+1)'(DEPTH / 2);
    localparam logic [ASIZE:0] LVL_QTR  = (ASIZE+1)'(DEPTH / 4);

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             wovf_q, wovf_d;
    logic             rudf_q, rudf_d;
    logic             full, empty, wr_ok, rd_ok;

    // Flags decode the count register only, so requests never reach them.
    assign full  = (count_q == LVL_FULL);
    assign empty = (count_q == '0);
    assign wr_ok = bus.winc && !full  && !bus.flush;
    assign rd_ok = bus.rinc && !empty && !bus.flush;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        wovf_d  = wovf_q;
        rudf_d  = rudf_q;
        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            wovf_d  = 1'b0;
            rudf_d  = 1'b0;
        end else begin
            if (bus.winc && full)  wovf_d = 1'b1;
            if (bus.rinc && empty) rudf_d = 1'b1;
            if (wr_ok) wptr_d = wptr_q + ASIZE'(1);
            if (rd_ok) begin
                rptr_d  = rptr_q + ASIZE'(1);
                rdata_d = mem_q[rptr_q];
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (ASIZE+1)'(1);
                2'b01:   count_d = count_q - (ASIZE+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
            wovf_q  <= 1'b0;
            rudf_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            wovf_q  <= wovf_d;
            rudf_q  <= rudf_d;
        end
    end

    // Storage needs no reset: the pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= bus.wdata;
    end

    assign bus.rdata  = rdata_q;
    assign bus.count  = count_q;
    assign bus.wfull  = full;
    assign bus.tfull  = (count_q >= LVL_TQ);
    assign bus.hfull  = (count_q >= LVL_HALF);
    assign bus.qfull  = (count_q >= LVL_QTR);
    assign bus.rempty = empty;
    assign bus.afull  = (count_q >= bus.af_level);
    assign bus.aempty = (count_q <= bus.ae_level);
    assign bus.wovf   = wovf_q;
    assign bus.rudf   = rudf_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl (DEPTH=16): fill/drain, errors, simultaneous
// access, pointer wrap, programmable levels, flush and asynchronous reset.
module tb_sync_fifo_lvl;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [7:0] exp_q[$];
  logic [7:0] m_rdata;
  logic       m_wovf;
  logic       m_rudf;

  sync_fifo_lvl_if #(.DSIZE(8), .ASIZE(4)) bus ();

  sync_fifo_lvl #(.DSIZE(8), .ASIZE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = exp_q.size();
    check_eq({tag, ".count"},  32'(bus.count),  32'(n));
    check_eq({tag, ".rempty"}, 32'(bus.rempty), 32'(n == 0));
    check_eq({tag, ".wfull"},  32'(bus.wfull),  32'(n == 16));
    check_eq({tag, ".tfull"},  32'(bus.tfull),  32'(n >= 12));
    check_eq({tag, ".hfull"},  32'(bus.hfull),  32'(n >= 8));
    check_eq({tag, ".qfull"},  32'(bus.qfull),  32'(n >= 4));
    check_eq({tag, ".afull"},  32'(bus.afull),  32'(n >= int'(bus.af_level)));
    check_eq({tag, ".aempty"}, 32'(bus.aempty), 32'(n <= int'(bus.ae_level)));
    check_eq({tag, ".wovf"},   32'(bus.wovf),   32'(m_wovf));
    check_eq({tag, ".rudf"},   32'(bus.rudf),   32'(m_rudf));
    check_eq({tag, ".rdata"},  32'(bus.rdata),  32'(m_rdata));
  endtask

  // driver: one clock with the given requests, then update scoreboard and check
  task automatic cycle(input string tag, input logic w, input logic r, input logic f,
                       input logic [7:0] d);
    logic full, empty;
    full  = (exp_q.size() == 16);
    empty = (exp_q.size() == 0);
    bus.winc = w; bus.rinc = r; bus.flush = f; bus.wdata = d;
    @(posedge clk);
    #1;
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.flush = 1'b0;
    if (f) begin
      exp_q.delete();
      m_wovf = 1'b0;
      m_rudf = 1'b0;
    end else begin
      if (w && full)  m_wovf = 1'b1;
      if (r && empty) m_rudf = 1'b1;
      if (r && !empty) m_rdata = exp_q.pop_front();
      if (w && !full)  exp_q.push_back(d);
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rdata = 8'h00;
    m_wovf  = 1'b0;
    m_rudf  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n = 1'b0;
    bus.winc = 1'b0; bus.rinc = 1'b0; bus.flush = 1'b0; bus.wdata = 8'h00;
    bus.af_level = 5'd10;
    bus.ae_level = 5'd3;
    #1;
    check_all("reset");
    check_eq("reset.rempty_const", 32'(bus.rempty), 32'd1);
    #13;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fill 0x00..0x0F; afull rises at 10, aempty falls at 4
    for (int i = 0; i < 16; i++) begin
      cycle("fill", 1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 3)  check_eq("fill.qfull_at4",  32'(bus.qfull),  32'd1);
      if (i == 3)  check_eq("fill.aempty_at4", 32'(bus.aempty), 32'd0);
      if (i == 8)  check_eq("fill.afull_at9",  32'(bus.afull),  32'd0);
      if (i == 9)  check_eq("fill.afull_at10", 32'(bus.afull),  32'd1);
      if (i == 11) check_eq("fill.tfull_at12", 32'(bus.tfull),  32'd1);
    end
    check_eq("fill.wfull_const", 32'(bus.wfull), 32'd1);

    cycle("ovf", 1'b1, 1'b0, 1'b0, 8'hFF);
    check_eq("ovf.count_const", 32'(bus.count), 32'd16);
    check_eq("ovf.wovf_const",  32'(bus.wovf),  32'd1);

    for (int i = 0; i < 16; i++) begin
      cycle("drain", 1'b0, 1'b1, 1'b0, 8'h00);
      check_eq("drain.rdata_const", 32'(bus.rdata), 32'(i));
    end
    check_eq("drain.rempty_const", 32'(bus.rempty), 32'd1);

    cycle("udf", 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("udf.rdata_const", 32'(bus.rdata), 32'h0F);
    check_eq("udf.rudf_const",  32'(bus.rudf),  32'd1);
    check_eq("udf.wovf_kept",   32'(bus.wovf),  32'd1);

    // empty with simultaneous requests: write accepted, read refused
    cycle("sim_empty", 1'b1, 1'b1, 1'b0, 8'h33);
    check_eq("sim_empty.count_const", 32'(bus.count), 32'd1);
    check_eq("sim_empty.rdata_const", 32'(bus.rdata), 32'h0F);
    cycle("sim_empty_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("sim_empty_rd.rdata_const", 32'(bus.rdata), 32'h33);

    cycle("flush1", 1'b0, 1'b0, 1'b1, 8'h00);
    check_eq("flush1.rudf_const", 32'(bus.rudf), 32'd0);

    // full with simultaneous requests: read accepted, write refused
    for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    cycle("sim_full", 1'b1, 1'b1, 1'b0, 8'hEE);
    check_eq("sim_full.count_const", 32'(bus.count), 32'd15);
    check_eq("sim_full.wovf_const",  32'(bus.wovf),  32'd1);
    check_eq("sim_full.rdata_const", 32'(bus.rdata), 32'h40);
    for (int i = 0; i < 15; i++) cycle("drain2", 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("drain2.last_const", 32'(bus.rdata), 32'h4F);

    // steady state at count 7 across pointer wrap
    cycle("flush2", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) cycle("pre7", 1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
    for (int i = 0; i < 40; i++) cycle("wrap", 1'b1, 1'b1, 1'b0, 8'(8'h80 + i));
    check_eq("wrap.count_const", 32'(bus.count), 32'd7);
    check_eq("wrap.rdata_const", 32'(bus.rdata), 32'hA0);

    // threshold change is seen without a clock edge
    check_eq("lvl.afull_af10", 32'(bus.afull), 32'd0);
    bus.af_level = 5'd5;
    #1;
    check_eq("lvl.afull_af5", 32'(bus.afull), 32'd1);
    bus.af_level = 5'd0;
    bus.ae_level = 5'd16;
    #1;
    check_eq("lvl.afull_af0",   32'(bus.afull),  32'd1);
    check_eq("lvl.aempty_ae16", 32'(bus.aempty), 32'd1);
    bus.af_level = 5'd10;
    bus.ae_level = 5'd3;

    // flush beats simultaneous requests
    cycle("flush3", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) cycle("fill3", 1'b1, 1'b0, 1'b0, 8'(i));
    cycle("ovf3", 1'b1, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 7; i++) cycle("rd7", 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("pre_flush.count_const", 32'(bus.count), 32'd9);
    cycle("flush_rw", 1'b1, 1'b1, 1'b1, 8'h5A);
    check_eq("flush_rw.count_const", 32'(bus.count), 32'd0);
    check_eq("flush_rw.wovf_const",  32'(bus.wovf),  32'd0);
    check_eq("flush_rw.rdata_const", 32'(bus.rdata), 32'h06);
    cycle("post_wr", 1'b1, 1'b0, 1'b0, 8'hA5);
    cycle("post_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("post_rd.rdata_const", 32'(bus.rdata), 32'hA5);

    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) cycle("burst", 1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    cycle("burst_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst.rdata_const", 32'(bus.rdata), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("after_rst_wr", 1'b1, 1'b0, 1'b0, 8'h3C);
    cycle("after_rst_rd", 1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("after_rst.rdata_const", 32'(bus.rdata), 32'h3C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end
endmodule
